// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexes eight frame-snapshotted hex digits onto an 8-digit common-anode 7-seg display.
// Latency: inputs are sampled once per frame in LOAD; frame = 1 + 8*(GAP+DIV) cycles; all outputs registered.
// Backpressure: none; free-running scan, Frame_done pulses for the single LOAD cycle that closes a frame.
module seg_scan_driver #(
    parameter int DIV = 50000,
    parameter int GAP = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [3:0] Din0,
    input  logic [3:0] Din1,
    input  logic [3:0] Din2,
    input  logic [3:0] Din3,
    input  logic [3:0] Din4,
    input  logic [3:0] Din5,
    input  logic [3:0] Din6,
    input  logic [3:0] Din7,
    input  logic       Blank_lz,
    input  logic [7:0] Dp_sel,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       Frame_done
);

    localparam int MAXC = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    // GAP=0 never enters the GAP state, so its terminal count is irrelevant then.
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t          state_q;
    logic [2:0]      idx_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0][3:0] shadow_q;
    logic [7:0]      mask_q;
    logic [7:0]      dpsh_q;
    logic [7:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic            fd_q;

    logic [7:0][3:0] din_pk;
    logic [7:0]      mask_d;
    logic            zero_run;

    // Digit about to be lit on the next SHOW entry, and its output pattern.
    logic [2:0]      nx_idx;
    logic [3:0]      nx_dig;
    logic            nx_blank;
    logic            nx_dpen;
    logic [7:0]      nx_an;
    logic [6:0]      nx_seg;
    logic            nx_dp;

    assign din_pk = {Din7, Din6, Din5, Din4, Din3, Din2, Din1, Din0};

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign Frame_done = fd_q;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Leading-zero mask: walk from the leftmost digit while digits stay zero; digit 0 always lit.
    always_comb begin
        mask_d   = '0;
        zero_run = Blank_lz;
        for (int k = 7; k >= 1; k--) begin
            zero_run  = zero_run & (din_pk[k] == 4'd0);
            mask_d[k] = zero_run;
        end
    end

    // Select the digit for the next SHOW entry; LOAD with GAP=0 must bypass the not-yet-written shadow.
    always_comb begin
        nx_idx   = 3'd0;
        nx_dig   = Din0;
        nx_blank = 1'b0;
        nx_dpen  = Dp_sel[0];
        case (state_q)
            S_GAP: begin
                nx_idx   = idx_q;
                nx_dig   = shadow_q[idx_q];
                nx_blank = mask_q[idx_q];
                nx_dpen  = dpsh_q[idx_q];
            end
            S_SHOW: begin
                nx_idx   = 3'(idx_q + 3'd1);
                nx_dig   = shadow_q[nx_idx];
                nx_blank = mask_q[nx_idx];
                nx_dpen  = dpsh_q[nx_idx];
            end
            default: ;
        endcase
        nx_an  = nx_blank ? 8'hFF : ~(8'h01 << nx_idx);
        nx_seg = nx_blank ? 7'h7F : hex_decode(nx_dig);
        nx_dp  = nx_blank ? 1'b1  : ~nx_dpen;
    end

    // Scan FSM; outputs are loaded on the edge entering each state and held through it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_LOAD;
            idx_q    <= 3'd0;
            cnt_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            dpsh_q   <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    shadow_q <= din_pk;
                    dpsh_q   <= Dp_sel;
                    mask_q   <= mask_d;
                    idx_q    <= 3'd0;
                    cnt_q    <= '0;
                    if (GAP == 0) begin
                        state_q <= S_SHOW;
                        an_q    <= nx_an;
                        seg_q   <= nx_seg;
                        dp_q    <= nx_dp;
                    end else begin
                        state_q <= S_GAP;
                        an_q    <= 8'hFF;
                        seg_q   <= 7'h7F;
                        dp_q    <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_SHOW;
                        cnt_q   <= '0;
                        an_q    <= nx_an;
                        seg_q   <= nx_seg;
                        dp_q    <= nx_dp;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= S_LOAD;
                            idx_q   <= 3'd0;
                            fd_q    <= 1'b1;
                            an_q    <= 8'hFF;
                            seg_q   <= 7'h7F;
                            dp_q    <= 1'b1;
                        end else begin
                            idx_q <= nx_idx;
                            if (GAP == 0) begin
                                state_q <= S_SHOW;
                                an_q    <= nx_an;
                                seg_q   <= nx_seg;
                                dp_q    <= nx_dp;
                            end else begin
                                state_q <= S_GAP;
                                an_q    <= 8'hFF;
                                seg_q   <= 7'h7F;
                                dp_q    <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                    cnt_q   <= '0;
                    an_q    <= 8'hFF;
                    seg_q   <= 7'h7F;
                    dp_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (GAP=1 and GAP=0, both DIV=3) driven from shared digit inputs.
// Expected per-cycle {AN,SEG,DP,Frame_done} words are queued per frame and popped on every falling edge.
// Async reset is exercised mid-frame on both instances.
module tb_seg_scan_driver;

    logic       Clk = 1'b0;
    logic       rst_a_n;
    logic       rst_b_n;
    logic [3:0] din [8];
    logic       blank_lz;
    logic [7:0] dp_sel;

    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fd_a, fd_b;

    int errors = 0;
    int checks = 0;
    logic [16:0] qa [$];
    logic [16:0] qb [$];
    logic [6:0]  seg_tab [16];
    string       phase = "init";

    localparam logic [16:0] OFF_WORD = {8'hFF, 7'h7F, 1'b1, 1'b0};

    always #5 Clk = ~Clk;

    seg_scan_driver #(.DIV(3), .GAP(1)) dut_a (
        .Clk(Clk), .Rst_n(rst_a_n),
        .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
        .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
        .Blank_lz(blank_lz), .Dp_sel(dp_sel),
        .AN(an_a), .SEG(seg_a), .DP(dp_a), .Frame_done(fd_a)
    );

    seg_scan_driver #(.DIV(3), .GAP(0)) dut_b (
        .Clk(Clk), .Rst_n(rst_b_n),
        .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
        .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
        .Blank_lz(blank_lz), .Dp_sel(dp_sel),
        .AN(an_b), .SEG(seg_b), .DP(dp_b), .Frame_done(fd_b)
    );

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
        end
    endtask

    // Queue one full frame of expected cycle words, using the inputs present now (sampled at LOAD).
    task automatic push_frame(input bit inst_b, input bit fd_first);
        logic [7:0]  m;
        logic [7:0]  onehot;
        logic [16:0] w;
        bit          run;
        int          g;
        g   = inst_b ? 0 : 1;
        m   = 8'h00;
        run = blank_lz;
        for (int k = 7; k >= 1; k--) begin
            if (run && din[k] == 4'd0) m[k] = 1'b1;
            else run = 1'b0;
        end
        w = {8'hFF, 7'h7F, 1'b1, fd_first};
        if (inst_b) qb.push_back(w); else qa.push_back(w);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < g; j++) begin
                if (inst_b) qb.push_back(OFF_WORD); else qa.push_back(OFF_WORD);
            end
            onehot = 8'h01 << k;
            if (m[k]) w = OFF_WORD;
            else      w = {~onehot, seg_tab[din[k]], ~dp_sel[k], 1'b0};
            for (int j = 0; j < 3; j++) begin
                if (inst_b) qb.push_back(w); else qa.push_back(w);
            end
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        if (qa.size() > 0) check("a_cycle", {an_a, seg_a, dp_a, fd_a}, qa.pop_front());
        if (qb.size() > 0) check("b_cycle", {an_b, seg_b, dp_b, fd_b}, qb.pop_front());
        @(posedge Clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_count_up();
        for (int k = 0; k < 8; k++) din[k] = 4'(k);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;
        blank_lz = 1'b0;
        dp_sel   = 8'h00;
        set_count_up();

        // Reset values while held in reset
        phase = "reset";
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_an",  {9'h0, an_a},   {9'h0, 8'hFF});
        check("rst_seg", {10'h0, seg_a}, {10'h0, 7'h7F});
        check("rst_dp",  {16'h0, dp_a},  {16'h0, 1'b1});
        check("rst_fd",  {16'h0, fd_a},  17'h0);

        // Count-up digits, first frame after release then a normal frame
        @(posedge Clk); #1;
        rst_a_n = 1'b1;
        phase = "count_f1";
        push_frame(1'b0, 1'b0);
        run_cycles(33);

        // Change digits during digit 2 SHOW; current frame keeps the old snapshot
        phase = "midchange";
        push_frame(1'b0, 1'b1);
        run_cycles(11);
        for (int k = 0; k < 8; k++) din[k] = 4'h8;
        run_cycles(22);
        phase = "all8";
        push_frame(1'b0, 1'b1);
        run_cycles(33);

        // Leading-zero blanking
        phase = "blank_5";
        blank_lz = 1'b1;
        for (int k = 0; k < 8; k++) din[k] = 4'h0;
        din[4] = 4'h5;
        push_frame(1'b0, 1'b1);
        run_cycles(33);
        phase = "blank_all0";
        din[4] = 4'h0;
        push_frame(1'b0, 1'b1);
        run_cycles(33);

        // Decimal point on digit 2 only
        phase = "dp2";
        blank_lz = 1'b0;
        set_count_up();
        dp_sel = 8'h04;
        push_frame(1'b0, 1'b1);
        run_cycles(33);

        // Asynchronous reset between edges during digit 5 SHOW
        phase = "async_a";
        push_frame(1'b0, 1'b1);
        run_cycles(22);
        check("pre_rst_an", {9'h0, an_a}, {9'h0, 8'hDF});
        #2 rst_a_n = 1'b0;
        #1 check("async_rst", {an_a, seg_a, dp_a, fd_a}, OFF_WORD);
        qa.delete();
        @(posedge Clk); #1;
        rst_a_n = 1'b1;
        phase = "after_rst_a";
        push_frame(1'b0, 1'b0);
        run_cycles(33);

        // GAP=0 instance: back-to-back digits, 25-cycle frame
        rst_a_n = 1'b0;
        dp_sel  = 8'h00;
        set_count_up();
        phase = "gap0";
        rst_b_n = 1'b1;
        push_frame(1'b1, 1'b0);
        run_cycles(25);
        push_frame(1'b1, 1'b1);
        run_cycles(16);
        check("b_pre_rst_an", {9'h0, an_b}, {9'h0, 8'hDF});
        #2 rst_b_n = 1'b0;
        #1 check("b_async_rst", {an_b, seg_b, dp_b, fd_b}, OFF_WORD);
        qb.delete();
        @(posedge Clk); #1;
        rst_b_n = 1'b1;
        phase = "after_rst_b";
        push_frame(1'b1, 1'b0);
        run_cycles(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Reads the eight 4-bit hex digits held by the digit shift register and time-multiplexes them onto one 8-digit common-anode seven-segment display.
- Snapshots all digits once per frame, so a display frame never tears.
- Inserts an all-off guard interval between digits to prevent ghosting.
- Supports leading-zero blanking and per-digit decimal points.

Parameters:
- DIV, 50000: Clk cycles each digit is driven in SHOW. Must be ≥1.
- GAP, 4: Clk cycles of all-anodes-off before each digit. 0 means the GAP state is skipped.

Ports:
- Clk  input  1  system clock; all state changes on posedge.
- Rst_n  input  1  reset, asynchronous, active-low.
- Din0..Din7  input  4 each  hex digits. Din0 is the rightmost, least significant digit; Din7 is the leftmost.
- Blank_lz  input  1  when 1, leading zeros are blanked.
- Dp_sel  input  8  decimal point enable; bit k controls digit k.
- AN  output  8  anode selects, active-low; bit k drives digit k.
- SEG  output  7  segment lines {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point line, active-low.
- Frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous, active while Rst_n=0):
  - Outputs: AN=8'hFF, SEG=7'h7F, DP=1, Frame_done=0.
  - Internal: state=LOAD, idx=0, counters=0, shadow digits=0, blank mask=0, DP shadow=0.
  - Reset asserted mid-frame forces these values immediately, without waiting for a clock edge.
  - After release, operation restarts at LOAD.
- Moore machine: AN, SEG, DP and Frame_done are registers, loaded on the edge that enters a state and held for that whole state. No combinational path runs from inputs to outputs.
- LOAD (1 cycle):
  - Captures Din0..Din7 and Dp_sel into shadow registers; sets idx=0.
  - Computes the blank mask:
    - If Blank_lz=1, digits 7 down to 1 are blanked while they equal 0, stopping at the first nonzero digit.
    - Digit 0 is never blanked.
    - Blank_lz=0 gives an empty mask.
  - Outputs during LOAD: AN=FF, SEG=7F, DP=1.
  - Next state: GAP, or SHOW if GAP=0.
- GAP (GAP cycles):
  - Outputs: AN=FF, SEG=7F, DP=1.
  - Next state: SHOW.
- SHOW (DIV cycles), for digit idx:
  - AN = ~(1<<idx); SEG = hex decode of shadow[idx]; DP = ~dp_shadow[idx].
  - If the digit is blanked: AN=FF, SEG=7F, DP=1.
  - Exit when idx<7: idx+1, next state GAP (or SHOW if GAP=0).
  - Exit when idx=7: next state LOAD, and Frame_done=1 for exactly that LOAD cycle.
- Frame period = 1 + 8*(GAP+DIV) cycles.
- Input changes never affect the display until the next LOAD.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Counters: the prescaler counts 0..DIV-1 (or 0..GAP-1), sized $clog2(max(DIV,GAP)+1). It clears on every state entry and never wraps inside a state.

Test Plan (DIV=3, GAP=1, frame=33 cycles unless stated):
1. Hold Rst_n=0 → AN=FF, SEG=7F, DP=1, Frame_done=0. Release → 1 cycle LOAD, 1 cycle GAP (AN=FF), then 3 cycles AN=FE.
2. Din0..Din7=0..7, Blank_lz=0, Dp_sel=0:
   - Digit 3 SHOW → AN=F7, SEG=0110000, DP=1.
   - Digit 5 SHOW → AN=DF, SEG=0010010.
   - Frame_done pulses 1 cycle, every 33 cycles.
3. Change all Din to 8 during the digit 2 SHOW → digits 3..7 still display the old values this frame; all digits show SEG=0000000 from the next frame.
4. Blank_lz=1, Din7..Din0=0,0,0,5,0,0,0,0 → AN=FF during the digit 7/6/5 SHOW slots. Digit 4 shows 5; digits 3..0 show 0. With all digits 0, only digit 0 lights (AN=FE, SEG=1000000).
5. Dp_sel=8'h04 → DP=0 only during the digit 2 SHOW; DP=1 in every GAP and LOAD cycle.
6. Assert Rst_n=0 between clock edges mid-SHOW of digit 5 → outputs take their reset values before the next edge. After release, the first SHOW is digit 0. Repeat with GAP=0 → no all-off cycles between digits, frame=25.
